// File: rtl/block_regfile_ctrl.sv
// Write sequencer and commit scheduler placed in front of block_regfile.
// Optional commit-sweep timeout is enabled with `define REGFILE_CTRL_SYNC_TIMEOUT_EN.
module block_regfile_ctrl #(
    parameter int data_width   = 16,
    parameter int n_blocks     = 256,
    parameter int fifo_depth   = 4,
    parameter int sync_timeout = 1024
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [$clog2(n_blocks)-1:0]     n_active_blocks,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [$clog2(n_blocks)-1:0]     req_addr,
    input  logic                            req_select,
    input  logic [data_width-1:0]           req_value,
    input  logic                            commit_req,
    output logic                            commit_busy,
    output logic                            commit_done,
    output logic                            commit_error,
    output logic                            write_done,
    output logic [$clog2(n_blocks)-1:0]     rf_write_addr,
    output logic [data_width-1:0]           rf_write_value,
    output logic                            rf_write_select,
    output logic                            rf_write_enable,
    output logic                            rf_sync,
    input  logic                            rf_read_valid,
    input  logic                            rf_syncing,
    output logic [$clog2(fifo_depth):0]     fifo_count
);

    localparam int AW = $clog2(n_blocks);
    localparam int PW = $clog2(fifo_depth);
    localparam int CW = PW + 1;
    localparam int EW = AW + 1 + data_width;

    if (fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0 || sync_timeout < 1) begin : g_param_check
        $error("block_regfile_ctrl: fifo_depth must be a power of two >= 2 and sync_timeout >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_SETTLE1,
        S_SETTLE2,
        S_SYNC,
        S_SYNC_START,
        S_SYNC_RUN
    } state_t;

    state_t        state;
    logic [EW-1:0] fifo_mem [fifo_depth];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic          commit_accept;
    logic          go_sync;
    logic          finish_now;
    logic          timeout_hit;
    logic          pending_next;

    always_comb begin
        push          = req_valid && req_ready;
        fifo_empty    = (fifo_count == '0);
        pop           = (state == S_IDLE) && !fifo_empty && rf_read_valid && !rf_syncing;
        commit_accept = commit_req && !commit_busy;
        // A write pushed this edge must drain before the commit, so it blocks the sweep.
        go_sync       = (state == S_IDLE) && fifo_empty && !push && (commit_busy || commit_accept);
        finish_now    = ((state == S_SYNC) && (n_active_blocks == '0))
                      || ((state == S_SYNC_RUN) && !rf_syncing)
                      || timeout_hit;
        pending_next  = commit_accept || (commit_busy && !finish_now);

        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + CW'(1);
        end else if (!push && pop) begin
            count_next = fifo_count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            commit_busy <= 1'b0;
            req_ready   <= 1'b0;
        end else begin
            fifo_count  <= count_next;
            commit_busy <= pending_next;
            req_ready   <= (count_next != CW'(fifo_depth)) && !pending_next;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage holds data only; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {req_addr, req_select, req_value};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            rf_write_addr   <= '0;
            rf_write_select <= 1'b0;
            rf_write_value  <= '0;
            rf_write_enable <= 1'b0;
            rf_sync         <= 1'b0;
            write_done      <= 1'b0;
            commit_done     <= 1'b0;
        end else begin
            rf_write_enable <= 1'b0;
            rf_sync         <= 1'b0;
            write_done      <= 1'b0;
            commit_done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state           <= S_WRITE;
                        rf_write_enable <= 1'b1;
                        {rf_write_addr, rf_write_select, rf_write_value} <= fifo_mem[rd_ptr];
                    end else if (go_sync) begin
                        state <= S_SYNC;
                    end
                end
                S_WRITE: begin
                    state <= S_SETTLE1;
                end
                // Two settle cycles cover the register file's read-modify-write.
                S_SETTLE1: begin
                    state      <= S_SETTLE2;
                    write_done <= 1'b1;
                end
                S_SETTLE2: begin
                    state <= S_IDLE;
                end
                S_SYNC: begin
                    if (finish_now) begin
                        commit_done <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        rf_sync <= 1'b1;
                        state   <= S_SYNC_START;
                    end
                end
                S_SYNC_START: begin
                    if (finish_now) begin
                        commit_done <= 1'b1;
                        state       <= S_IDLE;
                    end else if (rf_syncing) begin
                        state <= S_SYNC_RUN;
                    end
                end
                S_SYNC_RUN: begin
                    if (finish_now) begin
                        commit_done <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef REGFILE_CTRL_SYNC_TIMEOUT_EN
    localparam int TW = $clog2(sync_timeout + 1);

    logic [TW-1:0] sync_cnt;

    assign timeout_hit = ((state == S_SYNC_START) || (state == S_SYNC_RUN))
                       && !((state == S_SYNC_RUN) && !rf_syncing)
                       && (sync_cnt == TW'(sync_timeout - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_cnt     <= '0;
            commit_error <= 1'b0;
        end else begin
            if (state == S_SYNC) begin
                sync_cnt <= '0;
            end else if ((state == S_SYNC_START) || (state == S_SYNC_RUN)) begin
                sync_cnt <= sync_cnt + TW'(1);
            end
            if (commit_accept) begin
                commit_error <= 1'b0;
            end else if (timeout_hit) begin
                commit_error <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit  = 1'b0;
    assign commit_error = 1'b0;
`endif

endmodule
